// File: rtl/ccd_adc_emulator.sv
// Stand-in for a linear CCD plus 16-bit serial ADC: tracks line/pixel position from the
// CCD clocks and answers ADC serial reads with a selectable test-pattern word.
module ccd_adc_emulator #(
    parameter int unsigned LINE_PIXELS = 2101,
    parameter int unsigned DARK_PIXELS = 16,
    parameter logic [15:0] DARK_LEVEL  = 16'h0400
) (
    input  logic        clk_80M,
    input  logic        rst_n,
    input  logic        ccd_p1,
    input  logic        ccd_sh,
    input  logic        adc_cs,
    input  logic        adc_sclk,
    output logic        adc_sdo,
    input  logic [1:0]  mode,
    input  logic [15:0] const_val,
    input  logic        clr_flags,
    output logic [15:0] line_count,
    output logic        short_xfer,
    output logic        pix_overrun
);

    localparam int unsigned PIX_W = ($clog2(LINE_PIXELS) > 12) ? $clog2(LINE_PIXELS) : 12;
    localparam logic [PIX_W-1:0] PIX_MAX  = PIX_W'(LINE_PIXELS - 1);
    localparam logic [PIX_W-1:0] DARK_END = PIX_W'(DARK_PIXELS);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic              p1_q, p1_d, sh_q, sh_d, cs_q, cs_d, sclk_q, sclk_d, clr_q;
    logic [1:0]        mode_q;
    logic [15:0]       const_q;
    logic [PIX_W-1:0]  pix_idx;
    logic [15:0]       shreg;
    logic [3:0]        bitcnt;
    logic [15:0]       pattern;

    logic p1_rise, sh_rise, cs_fall, cs_rise, sclk_fall, overrun_set;
    assign p1_rise     = p1_q & ~p1_d;
    assign sh_rise     = sh_q & ~sh_d;
    assign cs_fall     = ~cs_q & cs_d;
    assign cs_rise     = cs_q & ~cs_d;
    assign sclk_fall   = ~sclk_q & sclk_d;
    assign overrun_set = p1_rise && !sh_rise && (pix_idx == PIX_MAX);

    // Test-pattern word for the current line/pixel position
    always_comb begin
        pattern = 16'h0000;
        case (mode_q)
            2'd0: pattern = {pix_idx[11:0], 4'h0};
            2'd1: pattern = const_q;
            2'd2: pattern = (pix_idx[0] ^ line_count[0]) ? 16'hFFFF : 16'h0000;
            2'd3: pattern = {line_count[7:0], pix_idx[7:0]};
        endcase
        if ((pix_idx < DARK_END) && (mode_q != 2'd1)) begin
            pattern = DARK_LEVEL;
        end
    end

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            p1_q        <= 1'b0;
            p1_d        <= 1'b0;
            sh_q        <= 1'b0;
            sh_d        <= 1'b0;
            cs_q        <= 1'b1;
            cs_d        <= 1'b1;
            sclk_q      <= 1'b0;
            sclk_d      <= 1'b0;
            clr_q       <= 1'b0;
            mode_q      <= 2'd0;
            const_q     <= 16'h0000;
            pix_idx     <= '0;
            line_count  <= 16'h0000;
            short_xfer  <= 1'b0;
            pix_overrun <= 1'b0;
            shreg       <= 16'h0000;
            bitcnt      <= 4'd0;
            adc_sdo     <= 1'b0;
            state       <= IDLE;
        end else begin
            p1_q    <= ccd_p1;
            p1_d    <= p1_q;
            sh_q    <= ccd_sh;
            sh_d    <= sh_q;
            cs_q    <= adc_cs;
            cs_d    <= cs_q;
            sclk_q  <= adc_sclk;
            sclk_d  <= sclk_q;
            clr_q   <= clr_flags;
            mode_q  <= mode;
            const_q <= const_val;

            // Line/pixel tracking; a new line takes priority over a pixel step
            if (sh_rise) begin
                pix_idx    <= '0;
                line_count <= line_count + 16'd1;
            end else if (p1_rise && (pix_idx != PIX_MAX)) begin
                pix_idx <= pix_idx + PIX_W'(1);
            end

            if (clr_q) begin
                short_xfer  <= 1'b0;
                pix_overrun <= 1'b0;
            end
            if (overrun_set) begin
                pix_overrun <= 1'b1;
            end

            // Serial read engine; the word is frozen into shreg at the cs fall
            case (state)
                IDLE: begin
                    adc_sdo <= 1'b0;
                    if (cs_fall) begin
                        shreg   <= pattern;
                        bitcnt  <= 4'd15;
                        adc_sdo <= pattern[15];
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        adc_sdo    <= 1'b0;
                        short_xfer <= 1'b1;
                        state      <= IDLE;
                    end else if (sclk_fall && !cs_q) begin
                        if (bitcnt != 4'd0) begin
                            shreg   <= {shreg[14:0], 1'b0};
                            bitcnt  <= bitcnt - 4'd1;
                            adc_sdo <= shreg[14];
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        adc_sdo <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    adc_sdo <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccd_adc_emulator.sv
// Directed self-checking bench for ccd_adc_emulator: one task per scenario.
module tb_ccd_adc_emulator;

    logic        clk_80M = 1'b0;
    logic        rst_n;
    logic        ccd_p1, ccd_sh, adc_cs, adc_sclk, clr_flags;
    logic        adc_sdo, short_xfer, pix_overrun;
    logic [1:0]  mode;
    logic [15:0] const_val, line_count;

    int tests = 0;
    int fails = 0;

    ccd_adc_emulator dut (
        .clk_80M     (clk_80M),
        .rst_n       (rst_n),
        .ccd_p1      (ccd_p1),
        .ccd_sh      (ccd_sh),
        .adc_cs      (adc_cs),
        .adc_sclk    (adc_sclk),
        .adc_sdo     (adc_sdo),
        .mode        (mode),
        .const_val   (const_val),
        .clr_flags   (clr_flags),
        .line_count  (line_count),
        .short_xfer  (short_xfer),
        .pix_overrun (pix_overrun)
    );

    always #6 clk_80M = ~clk_80M;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_80M);
    endtask

    task automatic pulse_p1(input int n);
        repeat (n) begin
            ccd_p1 = 1'b1; cycles(1);
            ccd_p1 = 1'b0; cycles(1);
        end
    endtask

    task automatic pulse_sh(input int n);
        repeat (n) begin
            ccd_sh = 1'b1; cycles(1);
            ccd_sh = 1'b0; cycles(1);
        end
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1; cycles(1);
        clr_flags = 1'b0; cycles(3);
    endtask

    // Host read: cs low, then 1 cycle high / 1 cycle low sclk, sampling as sclk is driven low
    task automatic read_bits(input int nbits, output logic [15:0] w);
        adc_cs = 1'b0;
        cycles(3);
        w = 16'h0000;
        for (int i = 0; i < nbits; i++) begin
            adc_sclk = 1'b1; cycles(1);
            w = {w[14:0], adc_sdo};
            adc_sclk = 1'b0; cycles(1);
        end
    endtask

    task automatic end_read();
        cycles(1);
        adc_cs = 1'b1;
        cycles(3);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; adc_cs = 1'b1; adc_sclk = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_reset();
        logic [15:0] w;
        rst_n = 1'b0;
        cycles(3);
        tests++; if (adc_sdo !== 1'b0) begin fails++; $display("FAIL reset_sdo: got %b expected 0", adc_sdo); end
        tests++; if (line_count !== 16'h0000) begin fails++; $display("FAIL reset_line_count: got %h expected 0000", line_count); end
        tests++; if (short_xfer !== 1'b0) begin fails++; $display("FAIL reset_short_xfer: got %b expected 0", short_xfer); end
        tests++; if (pix_overrun !== 1'b0) begin fails++; $display("FAIL reset_pix_overrun: got %b expected 0", pix_overrun); end
        rst_n = 1'b1;
        cycles(2);
        // mode 0 at pixel 0 is a dark pixel
        read_bits(16, w);
        end_read();
        tests++; if (w !== 16'h0400) begin fails++; $display("FAIL reset_dark_read: got %h expected 0400", w); end
    endtask

    task automatic test_const();
        logic [15:0] w;
        mode = 2'd1; const_val = 16'hA5C3;
        cycles(2);
        read_bits(16, w);
        tests++; if (w !== 16'hA5C3) begin fails++; $display("FAIL const_read: got %h expected a5c3", w); end
        // extra sclk after the last bit must not move sdo off bit 0
        repeat (2) begin adc_sclk = 1'b1; cycles(1); adc_sclk = 1'b0; cycles(1); end
        cycles(2);
        tests++; if (adc_sdo !== 1'b1) begin fails++; $display("FAIL const_done_hold: got %b expected 1", adc_sdo); end
        end_read();
        tests++; if (adc_sdo !== 1'b0) begin fails++; $display("FAIL const_idle_sdo: got %b expected 0", adc_sdo); end
        tests++; if ({short_xfer, pix_overrun} !== 2'b00) begin fails++; $display("FAIL const_flags: got %b expected 00", {short_xfer, pix_overrun}); end
    endtask

    task automatic test_ramp();
        logic [15:0] w;
        mode = 2'd0;
        pulse_sh(1); pulse_p1(20); cycles(2);
        read_bits(16, w); end_read();
        tests++; if (w !== 16'h0140) begin fails++; $display("FAIL ramp_p20: got %h expected 0140", w); end
        pulse_sh(1); pulse_p1(5); cycles(2);
        read_bits(16, w); end_read();
        tests++; if (w !== 16'h0400) begin fails++; $display("FAIL ramp_dark_p5: got %h expected 0400", w); end
        pulse_p1(10); cycles(2);
        read_bits(16, w); end_read();
        tests++; if (w !== 16'h0400) begin fails++; $display("FAIL ramp_dark_p15: got %h expected 0400", w); end
        pulse_p1(1); cycles(2);
        read_bits(16, w); end_read();
        tests++; if (w !== 16'h0100) begin fails++; $display("FAIL ramp_first_light_p16: got %h expected 0100", w); end
        tests++; if (line_count !== 16'd2) begin fails++; $display("FAIL ramp_line_count: got %0d expected 2", line_count); end
    endtask

    task automatic test_tag_checker();
        logic [15:0] w;
        apply_reset();
        mode = 2'd3;
        pulse_sh(3); pulse_p1(40); cycles(2);
        read_bits(16, w); end_read();
        tests++; if (w !== 16'h0328) begin fails++; $display("FAIL tag_read: got %h expected 0328", w); end
        tests++; if (line_count !== 16'd3) begin fails++; $display("FAIL tag_line_count: got %0d expected 3", line_count); end
        mode = 2'd2; cycles(2);
        read_bits(16, w); end_read();
        tests++; if (w !== 16'hFFFF) begin fails++; $display("FAIL checker_l3_p40: got %h expected ffff", w); end
        pulse_p1(1); cycles(2);
        read_bits(16, w); end_read();
        tests++; if (w !== 16'h0000) begin fails++; $display("FAIL checker_l3_p41: got %h expected 0000", w); end
        pulse_sh(1); pulse_p1(17); cycles(2);
        read_bits(16, w); end_read();
        tests++; if (w !== 16'hFFFF) begin fails++; $display("FAIL checker_l4_p17: got %h expected ffff", w); end
    endtask

    task automatic test_short_xfer();
        logic [15:0] w;
        mode = 2'd1; const_val = 16'h1234;
        cycles(2);
        read_bits(8, w);
        end_read();
        tests++; if (w[7:0] !== 8'h12) begin fails++; $display("FAIL short_partial_bits: got %h expected 12", w[7:0]); end
        tests++; if (short_xfer !== 1'b1) begin fails++; $display("FAIL short_flag_set: got %b expected 1", short_xfer); end
        tests++; if (adc_sdo !== 1'b0) begin fails++; $display("FAIL short_sdo_idle: got %b expected 0", adc_sdo); end
        pulse_clr();
        tests++; if (short_xfer !== 1'b0) begin fails++; $display("FAIL short_flag_clear: got %b expected 0", short_xfer); end
        // sclk activity with cs high is ignored
        repeat (3) begin adc_sclk = 1'b1; cycles(1); adc_sclk = 1'b0; cycles(1); end
        cycles(2);
        tests++; if (adc_sdo !== 1'b0) begin fails++; $display("FAIL sclk_cs_high_sdo: got %b expected 0", adc_sdo); end
        read_bits(16, w); end_read();
        tests++; if (w !== 16'h1234) begin fails++; $display("FAIL short_next_read: got %h expected 1234", w); end
        tests++; if (short_xfer !== 1'b0) begin fails++; $display("FAIL short_flag_after_full: got %b expected 0", short_xfer); end
    endtask

    task automatic test_overrun();
        logic [15:0] w;
        mode = 2'd0;
        pulse_sh(1); pulse_p1(2100); cycles(2);
        tests++; if (pix_overrun !== 1'b0) begin fails++; $display("FAIL overrun_at_last_pixel: got %b expected 0", pix_overrun); end
        pulse_p1(2); cycles(2);
        tests++; if (pix_overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b expected 1", pix_overrun); end
        read_bits(16, w); end_read();
        tests++; if (w !== 16'h8340) begin fails++; $display("FAIL overrun_saturated_read: got %h expected 8340", w); end
        // clear and set in the same cycle: set wins
        clr_flags = 1'b1; ccd_p1 = 1'b1; cycles(1);
        clr_flags = 1'b0; ccd_p1 = 1'b0; cycles(3);
        tests++; if (pix_overrun !== 1'b1) begin fails++; $display("FAIL overrun_set_beats_clear: got %b expected 1", pix_overrun); end
        pulse_clr();
        tests++; if (pix_overrun !== 1'b0) begin fails++; $display("FAIL overrun_clear: got %b expected 0", pix_overrun); end
    endtask

    task automatic test_reset_mid_xfer();
        logic [15:0] w;
        mode = 2'd1; const_val = 16'hA7C3;
        cycles(2);
        adc_cs = 1'b0;
        cycles(3);
        repeat (6) begin adc_sclk = 1'b1; cycles(1); adc_sclk = 1'b0; cycles(1); end
        cycles(2);
        tests++; if (adc_sdo !== 1'b1) begin fails++; $display("FAIL mid_bit9: got %b expected 1", adc_sdo); end
        rst_n = 1'b0; adc_cs = 1'b1;
        #1;
        tests++; if (adc_sdo !== 1'b0) begin fails++; $display("FAIL mid_reset_sdo: got %b expected 0", adc_sdo); end
        cycles(1);
        rst_n = 1'b1;
        cycles(4);
        tests++; if (adc_sdo !== 1'b0) begin fails++; $display("FAIL mid_post_reset_idle: got %b expected 0", adc_sdo); end
        tests++; if (line_count !== 16'h0000) begin fails++; $display("FAIL mid_post_reset_lines: got %h expected 0000", line_count); end
        read_bits(16, w); end_read();
        tests++; if (w !== 16'hA7C3) begin fails++; $display("FAIL mid_clean_read: got %h expected a7c3", w); end
        tests++; if (short_xfer !== 1'b0) begin fails++; $display("FAIL mid_short_flag: got %b expected 0", short_xfer); end
    endtask

    initial begin
        rst_n = 1'b0; ccd_p1 = 1'b0; ccd_sh = 1'b0; adc_cs = 1'b1; adc_sclk = 1'b0;
        mode = 2'd0; const_val = 16'h0000; clr_flags = 1'b0;
        test_reset();
        test_const();
        test_ramp();
        test_tag_checker();
        test_short_xfer();
        test_overrun();
        test_reset_mid_xfer();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
